// File: rtl/nibble_add_sequencer.sv
// Multi-precision add/subtract sequencer: one shared 4-bit carry-lookahead Adder
// is stepped over WIDTH/4 nibbles, LSB first, with the carry held in a register.

module Adder (
    input  logic [3:0] be_add_number,
    input  logic [3:0] add_number,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       Cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = be_add_number & add_number;
        p = be_add_number ^ add_number;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
        sum  = p ^ c[3:0];
        Cout = c[4];
    end
endmodule

module nibble_add_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             done_valid,
    input  logic             done_ready
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST  = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry_r;
    logic [IW-1:0]    idx;
    logic [3:0]       nib_a, nib_b, nib_sum;
    logic             nib_cout;
    logic             accept, last;

    assign start_ready = (state == IDLE) && rst_n;
    assign busy        = (state == RUN);
    assign done_valid  = (state == DONE);
    assign accept      = start_valid && start_ready;
    assign last        = (idx == LAST);

    // {idx, 2'b00} is the bit offset 4*idx of the active nibble
    always_comb begin
        nib_a = a_r[{idx, 2'b00} +: 4];
        nib_b = b_r[{idx, 2'b00} +: 4];
    end

    Adder u_adder (
        .be_add_number (nib_a),
        .add_number    (nib_b),
        .Cin           (carry_r),
        .sum           (nib_sum),
        .Cout          (nib_cout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (done_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r      <= op_a;
                        b_r      <= sub ? ~op_b : op_b;
                        carry_r  <= sub ? 1'b1 : cin;
                        idx      <= '0;
                        result   <= '0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RUN: begin
                    result[{idx, 2'b00} +: 4] <= nib_sum;
                    carry_r                   <= nib_cout;
                    if (last) begin
                        cout     <= nib_cout;
                        overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (nib_sum[3] != a_r[WIDTH-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed self-checking bench for nibble_add_sequencer (WIDTH=16).

module tb_nibble_add_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] op_a, op_b;
    logic        cin, sub;
    logic        busy;
    logic [15:0] result;
    logic        cout, overflow, done_valid;
    logic        done_ready;

    int checks = 0;
    int errors = 0;

    nibble_add_sequencer #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .busy        (busy),
        .result      (result),
        .cout        (cout),
        .overflow    (overflow),
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for done_valid; leaves DONE pending for the caller.
    task automatic issue(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s,
                         input logic [15:0] er, input logic ec, input logic eo);
        int cycles;
        int busy_cnt;
        check({tag, "_ready"}, start_ready, 1);
        op_a = a; op_b = b; cin = c; sub = s; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        op_a = 16'hDEAD; op_b = 16'hBEEF; cin = ~c; sub = ~s;
        cycles   = 0;
        busy_cnt = 0;
        while (!done_valid && cycles < 20) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, 4);
        check({tag, "_busycnt"}, busy_cnt, 4);
        check({tag, "_result"}, result, er);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, overflow, eo);
    endtask

    task automatic release_done(input string tag);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check({tag, "_done_clr"}, done_valid, 0);
        check({tag, "_idle_ready"}, start_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        #2;
        check("rst_ready", start_ready, 0);
        check("rst_done", done_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        #10 rst_n = 1'b1;
        tick();

        issue("add1", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        release_done("add1");
        issue("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        release_done("ripple");
        issue("ripcin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        release_done("ripcin");
        issue("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        release_done("sovf");
        issue("sub57", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        release_done("sub57");
        issue("sub80", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        release_done("sub80");
        issue("sub57c0", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        release_done("sub57c0");

        // Back-pressure: hold DONE, a competing request must be ignored.
        issue("bp", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                op_a = 16'hFFFF; op_b = 16'hFFFF; cin = 1'b1; sub = 1'b0; start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            tick();
            check("bp_hold_result", result, 16'h2345);
            check("bp_hold_valid", done_valid, 1);
            check("bp_hold_ready", start_ready, 0);
        end
        start_valid = 1'b0;
        release_done("bp");
        issue("bp_next", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        release_done("bp_next");

        // Reset mid-RUN aborts the operation.
        op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        tick();
        check("abort_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", overflow, 0);
        check("abort_done", done_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", start_ready, 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", start_ready, 1);
        begin
            int seen = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (done_valid || busy) seen++;
            end
            check("abort_no_done", seen, 0);
        end

        issue("post_rst", 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        release_done("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle, multi-precision add/subtract controller built around the 4-bit carry-lookahead `Adder` module. It accepts WIDTH-bit operands over a valid/ready handshake and feeds the single `Adder` instance one nibble per cycle, least significant first, carrying Cout into the next Cin through a register. It returns the WIDTH-bit result, carry and signed overflow through an output handshake. This is the shared-adder sequencer used wherever the datapath needs sums wider than 4 bits without replicating adder slices.

## Interface
- `WIDTH`, 16: operand and result width; must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  request valid.
- `start_ready`  out  1  sequencer can accept; equals (state==IDLE) && rst_n.
- `op_a`  in  WIDTH  augend/minuend; sampled only at accept.
- `op_b`  in  WIDTH  addend/subtrahend; sampled only at accept.
- `cin`  in  1  carry-in for add; ignored when `sub`=1.
- `sub`  in  1  1 = compute op_a − op_b.
- `busy`  out  1  high in RUN.
- `result`  out  WIDTH  registered sum or difference.
- `cout`  out  1  final carry-out; for subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement signed overflow.
- `done_valid`  out  1  result, cout and overflow are valid.
- `done_ready`  in  1  consumer takes result.

## Operation
- The FSM has states IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE → RUN** on start_valid && start_ready:
  - Capture a_r = op_a and b_r = sub ? ~op_b : op_b.
  - Set carry_r = sub ? 1 : cin, idx = 0, result = 0.
- **RUN**, each cycle, the `Adder` inputs are:
  - be_add_number = a_r[4·idx+3:4·idx]
  - add_number = b_r[4·idx+3:4·idx]
  - Cin = carry_r
- **RUN**, at each edge:
  - result[4·idx+3:4·idx] ← sum
  - carry_r ← Cout
  - idx ← idx+1
- **RUN → DONE** at the edge that processes idx = NIBBLES−1. On that edge:
  - cout ← Cout
  - overflow ← (a_r[MSB] == b_r[MSB]) && (sum[3] != a_r[MSB])
- **DONE**: result, cout and overflow hold. done_valid = 1. On done_ready, go to IDLE.
- idx is a counter of ceil(log2(NIBBLES)) bits (minimum 1) and never wraps past NIBBLES−1.
- The input side is back-pressured in RUN and DONE: start_valid is ignored there and start_ready = 0. op_a, op_b, cin and sub may change freely after accept.
- Reset while rst_n is low, including mid-operation:
  - State goes to IDLE and the operation is aborted with no done_valid.
  - result = 0, cout = 0, overflow = 0, done_valid = 0, busy = 0, start_ready = 0.
  - Carry, index and operand registers clear.

## Timing
- Accept at edge E0 → state RUN for edges E1..E_NIBBLES. Nibble k is written at edge E(k+1).
- done_valid rises after edge E_NIBBLES, so latency is NIBBLES cycles (4 for WIDTH=16).
- If done_ready is high when done_valid rises, DONE is left at the next edge. Minimum issue interval is NIBBLES+2 cycles.
- done_valid remains high indefinitely until done_ready. Outputs are stable throughout DONE.
- All outputs are registered except start_ready, which is derived from state and rst_n.
- Reset deassertion is synchronized by the integrating block. The first accept can occur on the first edge with rst_n high.

## Test plan
- **Reset**: hold rst_n low mid-RUN → result=0, cout=0, overflow=0, done_valid=0, busy=0, start_ready=0 immediately. After release → start_ready=1 and no done_valid ever appears for the aborted operation.
- **Basic add**: 0x0000 + 0x0001, cin=0, sub=0 → result=0x0001, cout=0, overflow=0. done_valid exactly 4 cycles after accept; busy high for exactly 4 cycles.
- **Full ripple**: 0xFFFF + 0x0001 → result=0x0000, cout=1, overflow=0. Also 0xFFFF + 0x0000 with cin=1 gives the same result.
- **Signed overflow**: 0x7FFF + 0x0001 → result=0x8000, cout=0, overflow=1.
- **Subtract**:
  - 0x0005 − 0x0007 → 0xFFFE, cout=0, overflow=0.
  - 0x8000 − 0x0001 → 0x7FFF, cout=1, overflow=1.
  - In both cases cin=1 has no effect.
- **Back-pressure**:
  - Hold done_ready=0 for 10 cycles after done_valid → result held and start_ready=0. A start_valid pulse with new operands is not accepted.
  - Raise done_ready → IDLE next edge. The next request is accepted one edge later and its result is unaffected by the earlier operands.
